seq_detector_p: RTL and testbench

SEQ_DETECTOR_P -- requirements
Module: seq_detector_p

---
 rtl/seq_det_pkg.sv | 17 +
 rtl/sat_counter.sv | 19 +
 rtl/seq_detector_p.sv | 97 +++++++++
 tb/tb_seq_detector_p.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: FSM encodings and
// the legal parameter limits used by elaboration checks.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'b00,
    ST_FILL   = 2'b01,
    ST_ARMED  = 2'b10,
    ST_UNUSED = 2'b11
  } det_state_e;

  localparam int W_MIN     = 2;
  localparam int W_MAX     = 16;
  localparam int CNT_W_MIN = 1;
  localparam int CNT_W_MAX = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: increments on inc and sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_p.sv
// Serial pattern detector with loadable pattern, overlapping or
// non-overlapping matching, a registered match pulse and a match counter.
module seq_detector_p
  import seq_det_pkg::*;
#(
  parameter int           W           = 4,
  parameter logic [W-1:0] DEFAULT_PAT = W'(4'b1011),
  parameter bit           OVERLAP     = 1'b1,
  parameter int           CNT_W       = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             en,
  input  logic             x,
  input  logic             load,
  input  logic [W-1:0]     pat_in,
  output logic             Q,
  output logic [CNT_W-1:0] match_cnt,
  output logic [W-1:0]     pat,
  output logic [1:0]       state
);

  localparam int           FC_W = $clog2(W + 1);
  localparam logic [FC_W-1:0] FULL = FC_W'(W);

  if (W < W_MIN || W > W_MAX) begin : g_bad_w
    $error("seq_detector_p: W out of range");
  end
  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("seq_detector_p: CNT_W out of range");
  end

  logic [W-1:0]    pat_r;
  logic [W-1:0]    win_r;
  logic [W-1:0]    win_nxt;
  logic [FC_W-1:0] fcnt_r;
  logic [FC_W-1:0] fcnt_nxt;
  det_state_e      st_r;
  logic            q_r;
  logic            accept;
  logic            hit;

  // A bit is only taken when not overridden by load and the FSM is in a
  // legal state; the unused encoding spends its cycle recovering instead.
  assign accept   = en && !load && (st_r != ST_UNUSED);
  assign win_nxt  = {win_r[W-2:0], x};
  assign fcnt_nxt = (fcnt_r == FULL) ? FULL : fcnt_r + 1'b1;
  assign hit      = accept && (fcnt_nxt == FULL) && (win_nxt == pat_r);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pat_r  <= DEFAULT_PAT;
      win_r  <= '0;
      fcnt_r <= '0;
      st_r   <= ST_EMPTY;
      q_r    <= 1'b0;
    end else if (load) begin
      pat_r  <= pat_in;
      win_r  <= '0;
      fcnt_r <= '0;
      st_r   <= ST_EMPTY;
      q_r    <= 1'b0;
    end else if (st_r == ST_UNUSED) begin
      win_r  <= '0;
      fcnt_r <= '0;
      st_r   <= ST_EMPTY;
      q_r    <= 1'b0;
    end else if (en) begin
      win_r <= win_nxt;
      q_r   <= hit;
      // Non-overlapping mode discards the matched bits by restarting the fill.
      if (hit && !OVERLAP) begin
        fcnt_r <= '0;
        st_r   <= ST_EMPTY;
      end else begin
        fcnt_r <= fcnt_nxt;
        st_r   <= (fcnt_nxt == FULL) ? ST_ARMED : ST_FILL;
      end
    end else begin
      q_r <= 1'b0;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .Clk  (Clk),
    .Reset(Reset),
    .inc  (hit),
    .count(match_cnt)
  );

  assign Q     = q_r;
  assign pat   = pat_r;
  assign state = st_r;

endmodule

// File: tb/tb_seq_detector_p.sv
// Bench for seq_detector_p: three configurations driven in parallel and
// checked against a reference model through a scoreboard queue.
module tb_seq_detector_p;

  logic       Clk;
  logic       Reset;
  logic       en;
  logic       x;
  logic       load;
  logic [3:0] pat_in;

  logic       q0, q1, q2;
  logic [7:0] c0, c1;
  logic [1:0] c2;
  logic [3:0] p0, p1, p2;
  logic [1:0] s0, s1, s2;

  seq_detector_p #(.W(4), .DEFAULT_PAT(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .Clk(Clk), .Reset(Reset), .en(en), .x(x), .load(load), .pat_in(pat_in),
    .Q(q0), .match_cnt(c0), .pat(p0), .state(s0));

  seq_detector_p #(.W(4), .DEFAULT_PAT(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_no (
    .Clk(Clk), .Reset(Reset), .en(en), .x(x), .load(load), .pat_in(pat_in),
    .Q(q1), .match_cnt(c1), .pat(p1), .state(s1));

  seq_detector_p #(.W(4), .DEFAULT_PAT(4'b1111), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
    .Clk(Clk), .Reset(Reset), .en(en), .x(x), .load(load), .pat_in(pat_in),
    .Q(q2), .match_cnt(c2), .pat(p2), .state(s2));

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    string      tag;
    logic [2:0] q;
    logic [5:0] st;
    logic [11:0] pt;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [1:0] e2;
  } exp_t;

  typedef struct {
    logic en;
    logic x;
    logic q_ov;
    logic q_no;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   puls0 = 0, puls1 = 0, puls2 = 0;

  logic [3:0] m_win[3];
  logic [3:0] m_pat[3];
  int         m_fc[3];
  int         m_cnt[3];
  logic       m_q[3];
  int         cmax[3] = '{255, 255, 3};
  bit         ovl[3]  = '{1'b1, 1'b0, 1'b1};
  logic [3:0] dpat[3] = '{4'b1011, 4'b1011, 4'b1111};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic ld, input logic e,
                            input logic xi, input logic [3:0] pi);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        m_pat[i] = dpat[i]; m_win[i] = 4'b0; m_fc[i] = 0; m_q[i] = 1'b0; m_cnt[i] = 0;
      end else if (ld) begin
        m_pat[i] = pi; m_win[i] = 4'b0; m_fc[i] = 0; m_q[i] = 1'b0;
      end else if (e) begin
        m_win[i] = {m_win[i][2:0], xi};
        if (m_fc[i] < 4) m_fc[i]++;
        m_q[i] = (m_fc[i] == 4) && (m_win[i] == m_pat[i]);
        if (m_q[i]) begin
          if (m_cnt[i] < cmax[i]) m_cnt[i]++;
          if (!ovl[i]) m_fc[i] = 0;
        end
      end else begin
        m_q[i] = 1'b0;
      end
    end
  endtask

  function automatic logic [1:0] st_of(input int fc);
    if (fc == 0) return 2'b00;
    if (fc < 4)  return 2'b01;
    return 2'b10;
  endfunction

  task automatic cycle(input logic r, input logic ld, input logic e, input logic xi,
                       input logic [3:0] pi, input string tag);
    exp_t ex;
    exp_t got;
    @(negedge Clk);
    Reset = r; load = ld; en = e; x = xi; pat_in = pi;
    model_step(r, ld, e, xi, pi);
    ex.tag = tag;
    ex.q   = {m_q[2], m_q[1], m_q[0]};
    ex.st  = {st_of(m_fc[2]), st_of(m_fc[1]), st_of(m_fc[0])};
    ex.pt  = {m_pat[2], m_pat[1], m_pat[0]};
    ex.e0  = 8'(m_cnt[0]);
    ex.e1  = 8'(m_cnt[1]);
    ex.e2  = 2'(m_cnt[2]);
    sb.push_back(ex);
    @(posedge Clk);
    #1;
    got = sb.pop_front();
    check({got.tag, ".Q0"}, 32'(q0), 32'(got.q[0]));
    check({got.tag, ".Q1"}, 32'(q1), 32'(got.q[1]));
    check({got.tag, ".Q2"}, 32'(q2), 32'(got.q[2]));
    check({got.tag, ".st0"}, 32'(s0), 32'(got.st[1:0]));
    check({got.tag, ".st1"}, 32'(s1), 32'(got.st[3:2]));
    check({got.tag, ".st2"}, 32'(s2), 32'(got.st[5:4]));
    check({got.tag, ".pat0"}, 32'(p0), 32'(got.pt[3:0]));
    check({got.tag, ".pat1"}, 32'(p1), 32'(got.pt[7:4]));
    check({got.tag, ".pat2"}, 32'(p2), 32'(got.pt[11:8]));
    check({got.tag, ".cnt0"}, 32'(c0), 32'(got.e0));
    check({got.tag, ".cnt1"}, 32'(c1), 32'(got.e1));
    check({got.tag, ".cnt2"}, 32'(c2), 32'(got.e2));
    puls0 += int'(q0);
    puls1 += int'(q1);
    puls2 += int'(q2);
  endtask

  task automatic clear_pulses();
    puls0 = 0; puls1 = 0; puls2 = 0;
  endtask

  vec_t tbl[7];
  logic stream[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0};

    Reset = 1'b1; load = 1'b0; en = 1'b0; x = 1'b0; pat_in = 4'b0;

    // Reset state
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, "rst");
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 4'h0, "rst");
    check("reset_state_ov", 32'(s0), 32'h0);
    check("reset_pat_sat", 32'(p2), 32'hf);

    // Basic stream, overlapping and non-overlapping
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 1'b0, tbl[i].en, tbl[i].x, 4'h0, "tbl");
      check("tbl_q_ov", 32'(q0), 32'(tbl[i].q_ov));
      check("tbl_q_no", 32'(q1), 32'(tbl[i].q_no));
    end
    check("stream_cnt_ov", 32'(c0), 32'd2);
    check("stream_cnt_no", 32'(c1), 32'd1);
    check("stream_state_no", 32'(s1), 32'h1);

    // Same stream with idle gaps between bits
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, "gap_rst");
    clear_pulses();
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 1'b0, 1'b1, stream[i], 4'h0, "gap");
      cycle(1'b0, 1'b0, 1'b0, ~stream[i], 4'h0, "gap_idle");
      cycle(1'b0, 1'b0, 1'b0, stream[i], 4'h0, "gap_idle");
    end
    check("gap_pulses_ov", 32'(puls0), 32'd2);
    check("gap_pulses_no", 32'(puls1), 32'd1);
    check("gap_cnt_ov", 32'(c0), 32'd2);

    // Load with a concurrent bit, then an all-zero pattern
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, "ld_pre");
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, "ld_pre");
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, "ld");
    check("ld_state_ov", 32'(s0), 32'h0);
    check("ld_cnt_kept", 32'(c0), 32'd2);
    clear_pulses();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, "ld_z");
    check("ld_nomatch_early", 32'(puls0 + puls1 + puls2), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, "ld_z4");
    check("ld_match_ov", 32'(q0), 32'd1);
    check("ld_cnt_ov", 32'(c0), 32'd3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, "ld_z_more");

    // Saturation with all-ones pattern on a 2-bit counter
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, "sat_rst");
    clear_pulses();
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, "sat");
    check("sat_pulses", 32'(puls2), 32'd5);
    check("sat_cnt", 32'(c2), 32'd3);

    // Reset in the cycle that would complete a match
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, "rm_rst");
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, "rm");
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, "rm");
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, "rm");
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 4'h0, "rm_hit");
    check("rm_q", 32'(q0), 32'd0);
    check("rm_cnt", 32'(c0), 32'd0);
    check("rm_pat", 32'(p0), 32'hb);

    // Random traffic with occasional loads and resets
    for (int i = 0; i < 300; i++) begin
      logic       r, ld, e, xi;
      logic [3:0] pi;
      r  = ($urandom_range(0, 49) == 0);
      ld = ($urandom_range(0, 19) == 0);
      e  = ($urandom_range(0, 3) != 0);
      xi = 1'($urandom_range(0, 1));
      pi = 4'($urandom_range(0, 15));
      cycle(r, ld, e, xi, pi, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
